window_addr_sequencer: RTL and testbench

- Generates the SRAM read-address stream for a TAPS-row vertical window sweep over a raster image held in single-port-read SRAM, for the gaussian/convolution filter blocks.
- For each output pixel it issues TAPS addresses, newest row first, one row stride apart, then advances column-wise and row-wise.
- Replaces hand-written per-bench address schedules, with run-time start, back-pressure, completion and RAM-latency-aligned tap tags.

---
 rtl/window_addr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_window_addr_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_addr_sequencer.sv
// Purpose: SRAM read-address generator for a TAPS-row vertical window sweep over a raster image.
// Latency: first address one cycle after an accepted start; one address per cycle; tags RAM_LAT cycles after each handshake.
// Backpressure: rd_addr/rd_tap/rd_last hold while rd_valid && !rd_ready; the tag pipeline never stalls.
// Ports: clk/reset (sync, active-high); start/busy/done frame control;
//        rd_addr/rd_valid/rd_ready/rd_tap/rd_last address stream;
//        tag_valid/tag_tap/tag_pix_end/tag_last aligned with SRAM read data.
module window_addr_sequencer #(
    parameter int ADDR_W    = 20,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int TAPS      = 5,
    parameter int BASE_ADDR = 0,
    parameter int RAM_LAT   = 1,
    localparam int TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [TAP_W-1:0]  rd_tap,
    output logic              rd_last,
    output logic              tag_valid,
    output logic [TAP_W-1:0]  tag_tap,
    output logic              tag_pix_end,
    output logic              tag_last
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
    // Newest row of the first window: BASE + (TAPS-1) rows.
    localparam logic [ADDR_W-1:0] FIRST_ADDR =
        ADDR_W'(longint'(BASE_ADDR) + longint'(TAPS - 1) * longint'(IMG_W));
    // Degenerate frame that consists of a single address.
    localparam bit FIRST_LAST = (IMG_H == 1) && (IMG_W == 1) && (TAPS == 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [ADDR_W-1:0] centre;
    logic [RW-1:0]     r, r_nxt;
    logic [CW-1:0]     c, c_nxt;
    logic [TAP_W-1:0]  k, k_nxt;
    logic              k_end, c_end, last_nxt, hs;

    assign hs     = rd_valid && rd_ready;
    assign rd_tap = k;

    // Counter values after the current handshake; rd_last is registered
    // from these so it lines up with the address it marks.
    always_comb begin
        k_end = (k == TAP_W'(TAPS - 1));
        c_end = (c == CW'(IMG_W - 1));
        k_nxt = k;
        c_nxt = c;
        r_nxt = r;
        if (k_end) begin
            k_nxt = '0;
            if (c_end) begin
                c_nxt = '0;
                r_nxt = r + RW'(1);
            end else begin
                c_nxt = c + CW'(1);
            end
        end else begin
            k_nxt = k + TAP_W'(1);
        end
        last_nxt = (r_nxt == RW'(IMG_H - 1)) && (c_nxt == CW'(IMG_W - 1)) &&
                   (k_nxt == TAP_W'(TAPS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
            centre   <= '0;
            r        <= '0;
            c        <= '0;
            k        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        centre   <= FIRST_ADDR;
                        rd_addr  <= FIRST_ADDR;
                        rd_last  <= FIRST_LAST;
                        r        <= RW'(TAPS - 1);
                        c        <= '0;
                        k        <= '0;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (rd_last) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            done     <= 1'b1;
                            k        <= '0;
                        end else begin
                            k       <= k_nxt;
                            c       <= c_nxt;
                            r       <= r_nxt;
                            rd_last <= last_nxt;
                            // The raster is contiguous, so moving to the next
                            // pixel (even across a row) is always centre+1.
                            if (k_end) begin
                                centre  <= centre + ADDR_W'(1);
                                rd_addr <= centre + ADDR_W'(1);
                            end else begin
                                rd_addr <= rd_addr - STRIDE;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag shift register: free-running so tags stay aligned with SRAM q
    // regardless of consumer stalls. Fields are zeroed on empty slots.
    logic             tv  [RAM_LAT];
    logic [TAP_W-1:0] tt  [RAM_LAT];
    logic             tpe [RAM_LAT];
    logic             tl  [RAM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tv[i]  <= 1'b0;
                tt[i]  <= '0;
                tpe[i] <= 1'b0;
                tl[i]  <= 1'b0;
            end
        end else begin
            tv[0]  <= hs;
            tt[0]  <= hs ? k : '0;
            tpe[0] <= hs && k_end;
            tl[0]  <= hs && rd_last;
            for (int i = 1; i < RAM_LAT; i++) begin
                tv[i]  <= tv[i-1];
                tt[i]  <= tt[i-1];
                tpe[i] <= tpe[i-1];
                tl[i]  <= tl[i-1];
            end
        end
    end

    assign tag_valid   = tv[RAM_LAT-1];
    assign tag_tap     = tt[RAM_LAT-1];
    assign tag_pix_end = tpe[RAM_LAT-1];
    assign tag_last    = tl[RAM_LAT-1];

endmodule

// File: tb/tb_window_addr_sequencer.sv
// Purpose: directed self-checking bench for window_addr_sequencer (two configurations).
// Latency: checks first-address, done and RAM_LAT=2 tag timing against a bench model.
// Backpressure: exercises random rd_ready stalls and checks output stability.
module tb_window_addr_sequencer;

    localparam int FRAME_A = 5120;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Instance A: defaults, IMG_H=8, RAM_LAT=2
    logic        start_a, busy_a, done_a, rd_valid_a, rd_ready_a, rd_last_a;
    logic [19:0] rd_addr_a;
    logic [2:0]  rd_tap_a, tag_tap_a;
    logic        tag_valid_a, tag_pix_end_a, tag_last_a;

    // Instance B: row wrap config
    logic        start_b, busy_b, done_b, rd_valid_b, rd_ready_b, rd_last_b;
    logic [19:0] rd_addr_b;
    logic [1:0]  rd_tap_b, tag_tap_b;
    logic        tag_valid_b, tag_pix_end_b, tag_last_b;

    window_addr_sequencer #(.IMG_H(8), .RAM_LAT(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_addr(rd_addr_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
        .rd_tap(rd_tap_a), .rd_last(rd_last_a), .tag_valid(tag_valid_a),
        .tag_tap(tag_tap_a), .tag_pix_end(tag_pix_end_a), .tag_last(tag_last_a)
    );

    window_addr_sequencer #(.IMG_W(4), .IMG_H(6), .TAPS(3), .BASE_ADDR(100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
        .rd_tap(rd_tap_b), .rd_last(rd_last_b), .tag_valid(tag_valid_b),
        .tag_tap(tag_tap_b), .tag_pix_end(tag_pix_end_b), .tag_last(tag_last_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference address: BASE + r*IMG_W + c - k*IMG_W, r starting at TAPS-1.
    function automatic logic [19:0] exp_a(input int i);
        int pix, k, r, c;
        pix = i / 5;
        k   = i % 5;
        r   = 4 + pix / 256;
        c   = pix % 256;
        return 20'(r * 256 + c - k * 256);
    endfunction

    logic [19:0] addr_q[$];
    logic [2:0]  tap_q[$];
    bit          last_q[$];
    logic [19:0] ref_q[$];
    logic [19:0] b_q[$];
    bit          b_last_q[$];

    // Model RAM with 2-cycle read latency returning data = address.
    logic [19:0] ram_s1, ram_q;
    always @(posedge clk) begin
        ram_s1 <= rd_addr_a;
        ram_q  <= ram_s1;
    end

    // Tag monitor: expected tag = handshake observed two negedges earlier.
    int mon_idx = 0, tag_err = 0, tag_seen = 0, d1_i = 0, d2_i = 0;
    bit d1_v = 0, d2_v = 0;
    always @(negedge clk) begin
        #1;
        if (tag_valid_a !== d2_v) tag_err++;
        else if (d2_v) begin
            tag_seen++;
            if (tag_tap_a !== 3'(d2_i % 5) || tag_pix_end_a !== (d2_i % 5 == 4) ||
                tag_last_a !== (d2_i == FRAME_A - 1) || ram_q !== exp_a(d2_i))
                tag_err++;
        end
        d2_v = d1_v;
        d2_i = d1_i;
        if (reset) begin
            d1_v = 0; d2_v = 0; mon_idx = 0;
        end else begin
            d1_v = rd_valid_a && rd_ready_a;
            d1_i = mon_idx;
            if (d1_v) mon_idx = (mon_idx + 1) % FRAME_A;
        end
    end

    int done_cnt_a = 0;
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

    task automatic run_a(input bit rnd, input int abort_at, input bit poke, input string nm);
        bit stalled = 0, fin = 0, h_last = 0;
        logic [19:0] h_addr = '0;
        logic [2:0]  h_tap = '0;
        int guard = 0, stall_err = 0;
        addr_q.delete(); tap_q.delete(); last_q.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check({nm, "_busy_rise"}, busy_a, 1);
        check({nm, "_valid_rise"}, rd_valid_a, 1);
        while (!fin && guard < 30000) begin
            rd_ready_a = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_a = poke && addr_q.size() >= 100 && addr_q.size() < 103;
            if (stalled && (rd_valid_a !== 1'b1 || rd_addr_a !== h_addr ||
                            rd_tap_a !== h_tap || rd_last_a !== h_last))
                stall_err++;
            stalled = rd_valid_a && !rd_ready_a;
            h_addr = rd_addr_a; h_tap = rd_tap_a; h_last = rd_last_a;
            if (rd_valid_a && rd_ready_a) begin
                addr_q.push_back(rd_addr_a);
                tap_q.push_back(rd_tap_a);
                last_q.push_back(rd_last_a);
                if (rd_last_a || addr_q.size() == abort_at) fin = 1;
            end
            @(negedge clk);
            guard++;
        end
        start_a = 1'b0;
        rd_ready_a = 1'b1;
        check({nm, "_reached_end"}, fin, 1);
        check({nm, "_stall_stable_errs"}, stall_err, 0);
    endtask

    task automatic check_seq_a(input string nm);
        int errs = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== exp_a(i) || tap_q[i] !== 3'(i % 5) || last_q[i] !== (i == FRAME_A - 1))
                errs++;
        check({nm, "_seq_errs"}, errs, 0);
    endtask

    task automatic cmp_ref(input string nm);
        int errs = 0;
        if (addr_q.size() != ref_q.size()) errs++;
        else for (int i = 0; i < ref_q.size(); i++) if (addr_q[i] !== ref_q[i]) errs++;
        check({nm, "_same_as_s1"}, errs, 0);
    endtask

    int first_tab[10] = '{1024, 768, 512, 256, 0, 1025, 769, 513, 257, 1};
    int last_tab[5]   = '{2047, 1791, 1535, 1279, 1023};
    int b_tab[9]      = '{108, 104, 100, 111, 107, 103, 112, 108, 104};
    int b_idx[9]      = '{0, 1, 2, 9, 10, 11, 12, 13, 14};

    initial begin
        reset = 1'b1; start_a = 0; rd_ready_a = 1; start_b = 0; rd_ready_b = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", rd_valid_a, 0);
        check("rst_addr", rd_addr_a, 0);
        check("rst_tap", rd_tap_a, 0);
        check("rst_last", rd_last_a, 0);
        check("rst_tag", {tag_valid_a, tag_tap_a, tag_pix_end_a, tag_last_a}, 0);
        reset = 1'b0;

        // Full frame, rd_ready held high
        run_a(0, 0, 0, "s1");
        check("s1_done_pulse", done_a, 1);
        check("s1_busy_low", busy_a, 0);
        check("s1_valid_low", rd_valid_a, 0);
        check("s1_count", addr_q.size(), FRAME_A);
        for (int i = 0; i < 10; i++) check($sformatf("s1_first%0d", i), addr_q[i], first_tab[i]);
        for (int i = 0; i < 5; i++) check($sformatf("s1_last%0d", i), addr_q[FRAME_A - 5 + i], last_tab[i]);
        check("s1_rd_last_on_1023", last_q[FRAME_A - 1], 1);
        check_seq_a("s1");
        ref_q = addr_q;
        @(negedge clk);
        check("s1_done_one_cycle", done_a, 0);
        repeat (4) @(negedge clk);

        // Random stalls
        run_a(1, 0, 0, "s2");
        check("s2_done_pulse", done_a, 1);
        cmp_ref("s2");
        check_seq_a("s2");
        repeat (4) @(negedge clk);
        check("s2_done_count", done_cnt_a, 2);

        // Reset mid-frame after 37 handshakes
        run_a(0, 37, 0, "s3");
        check("s3_count", addr_q.size(), 37);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s3_valid_after_rst", rd_valid_a, 0);
        check("s3_busy_after_rst", busy_a, 0);
        check("s3_done_after_rst", done_a, 0);
        repeat (5) @(negedge clk);
        check("s3_no_done", done_cnt_a, 2);

        // Restart, with start poked while busy and during DONE
        run_a(0, 0, 1, "s4");
        check("s4_restart_1024", addr_q[0], 1024);
        check("s4_done_pulse", done_a, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("s4_start_in_done_busy", busy_a, 0);
        check("s4_start_in_done_valid", rd_valid_a, 0);
        repeat (3) @(negedge clk);
        check("s4_still_idle", busy_a, 0);
        cmp_ref("s4");
        check("s4_done_count", done_cnt_a, 3);
        check("tag_errs", tag_err, 0);
        check("tag_seen", tag_seen, 3 * FRAME_A + 36);

        // Row wrap configuration
        begin
            int guard = 0, nlast = 0;
            bit fin = 0;
            @(negedge clk); start_b = 1'b1;
            @(negedge clk); start_b = 1'b0;
            while (!fin && guard < 500) begin
                if (rd_valid_b && rd_ready_b) begin
                    b_q.push_back(rd_addr_b);
                    b_last_q.push_back(rd_last_b);
                    if (rd_last_b) fin = 1;
                end
                @(negedge clk);
                guard++;
            end
            check("b_reached_end", fin, 1);
            check("b_done_pulse", done_b, 1);
            check("b_count", b_q.size(), 48);
            for (int i = 0; i < 9; i++)
                if (b_idx[i] < b_q.size()) check($sformatf("b_addr%0d", b_idx[i]), b_q[b_idx[i]], b_tab[i]);
                else check($sformatf("b_addr%0d_missing", b_idx[i]), b_q.size(), b_idx[i] + 1);
            if (b_q.size() > 0) check("b_final_addr", b_q[b_q.size() - 1], 115);
            foreach (b_last_q[i]) if (b_last_q[i]) nlast++;
            check("b_last_count", nlast, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
